// File: rtl/wdt_timeout_core_if.sv
// Signal bundle between the watchdog AXI wrapper (master) and the counting core (slave).
// warn_o exists only when WDT_WARN_EN is defined.
interface wdt_timeout_core_if #(
   parameter int CNT_W = 32
);
   logic             wden_i;
   logic             wdlive_i;
   logic [CNT_W-1:0] wtocnt_i;
   logic             wtocnt_load_i;
   logic             wto_o;
   logic [CNT_W-1:0] cnt_o;
   logic [1:0]       state_o;
`ifdef WDT_WARN_EN
   logic             warn_o;

   modport master (
      output wden_i, wdlive_i, wtocnt_i, wtocnt_load_i,
      input  wto_o, cnt_o, state_o, warn_o
   );
   modport slave (
      input  wden_i, wdlive_i, wtocnt_i, wtocnt_load_i,
      output wto_o, cnt_o, state_o, warn_o
   );
`else
   modport master (
      output wden_i, wdlive_i, wtocnt_i, wtocnt_load_i,
      input  wto_o, cnt_o, state_o
   );
   modport slave (
      input  wden_i, wdlive_i, wtocnt_i, wtocnt_load_i,
      output wto_o, cnt_o, state_o
   );
`endif
endinterface

// File: rtl/wdt_timeout_core.sv
// Watchdog counting core: prescaled tick counter, programmable limit, WTO timeout level.
// Optional early-warning output warn_o is enabled by defining WDT_WARN_EN.
module wdt_timeout_core #(
   parameter int CNT_W    = 32,
   parameter int PRESCALE = 1
) (
   input logic              clk,
   input logic              rst,
   wdt_timeout_core_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COUNT   = 2'b01,
      ST_TIMEOUT = 2'b10
   } state_t;

   localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] limit_q;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             wto_q;
   logic             tick;

   assign tick = (pre_q == PRE_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pre_q   <= '0;
         limit_q <= '0;
         wto_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         wto_q   <= (state_d == ST_TIMEOUT);
         // The compare below still sees the old limit on the load edge
         if (bus.wtocnt_load_i) limit_q <= bus.wtocnt_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pre_d   = tick ? '0 : pre_q + PRE_W'(1);
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            pre_d = '0;
            if (bus.wden_i) state_d = ST_COUNT;
         end
         ST_COUNT: begin
            if (!bus.wden_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               pre_d   = '0;
            end else if (bus.wdlive_i) begin
               cnt_d = '0;
               pre_d = '0;
            end else if (tick) begin
               // ">=" so a limit lowered below the count still times out without wrapping
               if (cnt_q >= limit_q) state_d = ST_TIMEOUT;
               else                  cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_TIMEOUT: begin
            if (!bus.wden_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               pre_d   = '0;
            end else if (bus.wdlive_i) begin
               state_d = ST_COUNT;
               cnt_d   = '0;
               pre_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pre_d   = '0;
         end
      endcase
   end

   assign bus.wto_o   = wto_q;
   assign bus.cnt_o   = cnt_q;
   assign bus.state_o = state_q;

`ifdef WDT_WARN_EN
   assign bus.warn_o = (state_q != ST_IDLE) && (cnt_q >= (limit_q >> 1));
`endif

endmodule

// File: tb/tb_wdt_timeout_core.sv
// Bench for wdt_timeout_core: a PRESCALE=1 and a PRESCALE=4 instance driven with identical stimulus,
// checked by directed scenarios and a randomized run against a timing-level reference model.
module tb_wdt_timeout_core;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wdt_timeout_core_if #(.CNT_W(32)) b1 ();
   wdt_timeout_core_if #(.CNT_W(32)) b4 ();

   wdt_timeout_core #(.CNT_W(32), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
   wdt_timeout_core #(.CNT_W(32), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: index 0 is the PRESCALE=1 instance, index 1 the PRESCALE=4 instance
   int          m_pre   [2] = '{1, 4};
   bit          m_act   [2];
   bit          m_to    [2];
   int          m_phase [2];
   logic [31:0] m_cnt   [2];
   logic [31:0] m_lim   [2];

   logic [31:0] o_cnt   [2];
   logic [1:0]  o_state [2];
   logic        o_wto   [2];
   logic        o_warn  [2];

   task automatic model_edge(input int d, input bit r, input bit wd, input bit kk,
                             input bit ld, input logic [31:0] v);
      logic [31:0] lim_used;
      lim_used = m_lim[d];
      if (r) begin
         m_act[d] = 0; m_to[d] = 0; m_phase[d] = 0; m_cnt[d] = 0; m_lim[d] = 0;
         return;
      end
      if (ld) m_lim[d] = v;
      if (!m_act[d]) begin
         if (wd) begin m_act[d] = 1; m_cnt[d] = 0; m_phase[d] = 0; end
      end else if (!wd) begin
         m_act[d] = 0; m_to[d] = 0; m_cnt[d] = 0; m_phase[d] = 0;
      end else if (kk) begin
         m_to[d] = 0; m_cnt[d] = 0; m_phase[d] = 0;
      end else if (!m_to[d]) begin
         m_phase[d] = m_phase[d] + 1;
         if (m_phase[d] == m_pre[d]) begin
            m_phase[d] = 0;
            if (m_cnt[d] >= lim_used) m_to[d] = 1;
            else                      m_cnt[d] = m_cnt[d] + 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit wd, input bit kk, input bit ld, input logic [31:0] v);
      rst = r;
      b1.wden_i = wd; b1.wdlive_i = kk; b1.wtocnt_load_i = ld; b1.wtocnt_i = v;
      b4.wden_i = wd; b4.wdlive_i = kk; b4.wtocnt_load_i = ld; b4.wtocnt_i = v;
      @(posedge clk);
      for (int d = 0; d < 2; d++) model_edge(d, r, wd, kk, ld, v);
      #1;
      o_cnt[0] = b1.cnt_o; o_state[0] = b1.state_o; o_wto[0] = b1.wto_o;
      o_cnt[1] = b4.cnt_o; o_state[1] = b4.state_o; o_wto[1] = b4.wto_o;
`ifdef WDT_WARN_EN
      o_warn[0] = b1.warn_o; o_warn[1] = b4.warn_o;
`else
      o_warn[0] = 1'b0; o_warn[1] = 1'b0;
`endif
   endtask

   task automatic test_reset();
      step(1, 1, 1, 1, 32'd9);
      for (int d = 0; d < 2; d++) begin
         n_cmp++; if (o_cnt[d] !== 32'd0) begin n_bad++; $display("FAIL reset_cnt[%0d] got %0d exp 0", d, o_cnt[d]); end
         n_cmp++; if (o_state[d] !== 2'b00) begin n_bad++; $display("FAIL reset_state[%0d] got %0d exp 0", d, o_state[d]); end
         n_cmp++; if (o_wto[d] !== 1'b0) begin n_bad++; $display("FAIL reset_wto[%0d] got %0d exp 0", d, o_wto[d]); end
      end
   endtask

   task automatic test_basic_count();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'd3);
      step(0, 1, 0, 0, 0);
      n_cmp++; if (o_state[0] !== 2'b01 || o_cnt[0] !== 32'd0) begin
         n_bad++; $display("FAIL basic_entry state %0d cnt %0d exp 1/0", o_state[0], o_cnt[0]); end
      for (int k = 1; k <= 7; k++) begin
         step(0, 1, 0, 0, 0);
         n_cmp++; if (o_cnt[0] !== ((k < 3) ? 32'(k) : 32'd3)) begin
            n_bad++; $display("FAIL basic_cnt k=%0d got %0d exp %0d", k, o_cnt[0], (k < 3) ? k : 3); end
         n_cmp++; if (o_wto[0] !== (k >= 4)) begin
            n_bad++; $display("FAIL basic_wto k=%0d got %0d exp %0d", k, o_wto[0], k >= 4); end
         n_cmp++; if (o_state[0] !== ((k >= 4) ? 2'b10 : 2'b01)) begin
            n_bad++; $display("FAIL basic_state k=%0d got %0d", k, o_state[0]); end
      end
   endtask

   task automatic test_kick();
      bit kick_next;
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'd5);
      step(0, 1, 0, 0, 0);
      kick_next = 0;
      for (int k = 0; k < 20; k++) begin
         step(0, 1, kick_next, 0, 0);
         if (kick_next) begin
            n_cmp++; if (o_cnt[0] !== 32'd0) begin n_bad++; $display("FAIL kick_cnt got %0d exp 0", o_cnt[0]); end
         end
         n_cmp++; if (o_wto[0] !== 1'b0) begin n_bad++; $display("FAIL kick_wto k=%0d got %0d exp 0", k, o_wto[0]); end
         kick_next = (o_cnt[0] == 32'd3);
      end
   endtask

   task automatic test_timeout_exit();
      int k;
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'd1);
      step(0, 1, 0, 0, 0);
      k = 0;
      while (o_wto[0] !== 1'b1 && k < 10) begin step(0, 1, 0, 0, 0); k++; end
      n_cmp++; if (o_wto[0] !== 1'b1) begin n_bad++; $display("FAIL exit_wait_wto got %0d exp 1", o_wto[0]); end
      step(0, 1, 1, 0, 0);
      n_cmp++; if (o_wto[0] !== 1'b0 || o_state[0] !== 2'b01 || o_cnt[0] !== 32'd0) begin
         n_bad++; $display("FAIL exit_kick wto %0d state %0d cnt %0d exp 0/1/0", o_wto[0], o_state[0], o_cnt[0]); end
      step(0, 0, 0, 0, 0);
      n_cmp++; if (o_state[0] !== 2'b00) begin n_bad++; $display("FAIL exit_idle state %0d exp 0", o_state[0]); end
   endtask

   task automatic test_limit_edges();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'd0);
      step(0, 1, 0, 0, 0);
      n_cmp++; if (o_wto[0] !== 1'b0) begin n_bad++; $display("FAIL lim0_early wto %0d exp 0", o_wto[0]); end
      step(0, 1, 0, 0, 0);
      n_cmp++; if (o_wto[0] !== 1'b1 || o_cnt[0] !== 32'd0) begin
         n_bad++; $display("FAIL lim0_wto wto %0d cnt %0d exp 1/0", o_wto[0], o_cnt[0]); end
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'd20);
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0);
      n_cmp++; if (o_cnt[0] !== 32'd8) begin n_bad++; $display("FAIL lower_pre cnt %0d exp 8", o_cnt[0]); end
      step(0, 1, 0, 1, 32'd2);
      n_cmp++; if (o_cnt[0] !== 32'd9 || o_state[0] !== 2'b01) begin
         n_bad++; $display("FAIL lower_load cnt %0d state %0d exp 9/1", o_cnt[0], o_state[0]); end
      step(0, 1, 0, 0, 0);
      n_cmp++; if (o_state[0] !== 2'b10 || o_cnt[0] !== 32'd9 || o_wto[0] !== 1'b1) begin
         n_bad++; $display("FAIL lower_to state %0d cnt %0d wto %0d exp 2/9/1", o_state[0], o_cnt[0], o_wto[0]); end
   endtask

   task automatic test_prescale_rst();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'd2);
      step(0, 1, 0, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         step(0, 1, 0, 0, 0);
         n_cmp++; if (o_wto[1] !== (k == 12)) begin
            n_bad++; $display("FAIL pre4_wto k=%0d got %0d exp %0d", k, o_wto[1], k == 12); end
         n_cmp++; if (o_cnt[1] !== ((k >= 8) ? 32'd2 : 32'(k / 4))) begin
            n_bad++; $display("FAIL pre4_cnt k=%0d got %0d", k, o_cnt[1]); end
      end
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 32'd30);
      for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int d = 0; d < 2; d++) begin
         n_cmp++; if (o_cnt[d] !== 32'd0 || o_state[d] !== 2'b00 || o_wto[d] !== 1'b0 || o_warn[d] !== 1'b0) begin
            n_bad++; $display("FAIL midrst[%0d] cnt %0d state %0d wto %0d exp all 0", d, o_cnt[d], o_state[d], o_wto[d]); end
      end
      step(0, 0, 1, 0, 0);
      n_cmp++; if (o_state[0] !== 2'b00 || o_cnt[0] !== 32'd0) begin
         n_bad++; $display("FAIL idle_kick state %0d cnt %0d exp 0/0", o_state[0], o_cnt[0]); end
   endtask

`ifdef WDT_WARN_EN
   task automatic test_warn();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'd10);
      step(0, 1, 0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         step(0, 1, 0, 0, 0);
         n_cmp++; if (o_warn[0] !== (k >= 5)) begin
            n_bad++; $display("FAIL warn k=%0d got %0d exp %0d", k, o_warn[0], k >= 5); end
      end
      step(0, 1, 1, 0, 0);
      n_cmp++; if (o_warn[0] !== 1'b0) begin n_bad++; $display("FAIL warn_kick got %0d exp 0", o_warn[0]); end
   endtask
`endif

   task automatic test_random();
      bit r, wd, kk, ld;
      logic [31:0] v;
      logic [1:0]  es;
      bit          ew;
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 600; k++) begin
         r  = ($urandom_range(0, 99) == 0);
         wd = ($urandom_range(0, 19) != 0);
         kk = ($urandom_range(0, 9) == 0);
         ld = ($urandom_range(0, 7) == 0);
         v  = 32'($urandom_range(0, 6));
         step(r, wd, kk, ld, v);
         for (int d = 0; d < 2; d++) begin
            es = !m_act[d] ? 2'b00 : (m_to[d] ? 2'b10 : 2'b01);
            n_cmp++; if (o_cnt[d] !== m_cnt[d] || o_state[d] !== es || o_wto[d] !== m_to[d]) begin
               n_bad++;
               $display("FAIL rand[%0d] k=%0d cnt %0d/%0d state %0d/%0d wto %0d/%0d (got/exp)",
                        d, k, o_cnt[d], m_cnt[d], o_state[d], es, o_wto[d], m_to[d]);
            end
`ifdef WDT_WARN_EN
            ew = m_act[d] && (m_cnt[d] >= (m_lim[d] >> 1));
            n_cmp++; if (o_warn[d] !== ew) begin
               n_bad++; $display("FAIL rand_warn[%0d] k=%0d got %0d exp %0d", d, k, o_warn[d], ew); end
`else
            ew = 1'b0;
`endif
         end
      end
   endtask

   initial begin
      b1.wden_i = 0; b1.wdlive_i = 0; b1.wtocnt_load_i = 0; b1.wtocnt_i = '0;
      b4.wden_i = 0; b4.wdlive_i = 0; b4.wtocnt_load_i = 0; b4.wtocnt_i = '0;
      test_reset();
      test_basic_count();
      test_kick();
      test_timeout_exit();
      test_limit_edges();
      test_prescale_rst();
`ifdef WDT_WARN_EN
      test_warn();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: bench did not finish within the time limit");
      $fatal(1, "time limit");
   end

endmodule
